// File: rtl/mat_pkg.sv
// Shared types for the matrix tile cache: write/read access kinds and transpose FSM states.
package mat_pkg;

  typedef enum logic [1:0] {
    WRITE_DIAG = 2'd0,
    WRITE_ROW  = 2'd1,
    WRITE_COL  = 2'd2
  } MatCacheWriteOp_t;

  typedef enum logic [1:0] {
    READ_DIAG = 2'd0,
    READ_ROW  = 2'd1,
    READ_COL  = 2'd2
  } MatCacheReadOp_t;

  typedef enum logic {
    IDLE = 1'b0,
    SWAP = 1'b1
  } MatCacheTransState_t;

endpackage

// File: rtl/mat_tile_cache_if.sv
// Access bus of the matrix tile cache: write, registered read and transpose control.
interface mat_tile_cache_if #(
  parameter int WIDTH           = 128,
  parameter int DATA_WIDTH      = 32,
  parameter int CACHE_SIZE      = 4,
  parameter int WIDTH_ADDR_SIZE = 1 + $clog2(WIDTH),
  parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
);
  import mat_pkg::*;

  logic                            write_enable;
  MatCacheWriteOp_t                write_type;
  logic [CACHE_ADDR_SIZE-1:0]      write_addr1;
  logic [CACHE_ADDR_SIZE-1:0]      write_addr2;
  logic [WIDTH_ADDR_SIZE-1:0]      write_param;
  logic [WIDTH*DATA_WIDTH-1:0]     data_in;
  logic                            read_enable;
  MatCacheReadOp_t                 read_type;
  logic [CACHE_ADDR_SIZE-1:0]      read_addr1;
  logic [CACHE_ADDR_SIZE-1:0]      read_addr2;
  logic [WIDTH_ADDR_SIZE-1:0]      read_param;
  logic [WIDTH*DATA_WIDTH-1:0]     data_out;
  logic                            read_valid;
  logic                            read_error;
  logic                            transpose_start;
  logic [CACHE_ADDR_SIZE-1:0]      transpose_addr;
  logic                            busy;
  logic                            transpose_done;

  modport master (
    output write_enable, write_type, write_addr1, write_addr2, write_param, data_in,
    output read_enable, read_type, read_addr1, read_addr2, read_param,
    output transpose_start, transpose_addr,
    input  data_out, read_valid, read_error, busy, transpose_done
  );

  modport slave (
    input  write_enable, write_type, write_addr1, write_addr2, write_param, data_in,
    input  read_enable, read_type, read_addr1, read_addr2, read_param,
    input  transpose_start, transpose_addr,
    output data_out, read_valid, read_error, busy, transpose_done
  );

endinterface

// File: rtl/mat_cache_transpose_ctrl.sv
// In-place transpose sequencer: walks one row/column pair per cycle over the latched block.
module mat_cache_transpose_ctrl
  import mat_pkg::*;
#(
  parameter int WIDTH           = 128,
  parameter int CACHE_ADDR_SIZE = 2,
  parameter int ROW_W           = $clog2(WIDTH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       transpose_start_i,
  input  logic [CACHE_ADDR_SIZE-1:0] transpose_addr_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       swap_en_o,
  output logic [ROW_W-1:0]           swap_row_o,
  output logic [CACHE_ADDR_SIZE-1:0] swap_blk_o
);

  MatCacheTransState_t        state_q;
  logic [ROW_W-1:0]           row_q;
  logic [CACHE_ADDR_SIZE-1:0] blk_q;
  logic                       busy_q;
  logic                       done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      blk_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (transpose_start_i) begin
            state_q <= SWAP;
            blk_q   <= transpose_addr_i;
            row_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWAP: begin
          if (row_q == ROW_W'(WIDTH - 1)) begin
            state_q <= IDLE;
            row_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            row_q <= row_q + ROW_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign swap_en_o  = busy_q;
  assign swap_row_o = row_q;
  assign swap_blk_o = blk_q;

endmodule

// File: rtl/mat_tile_cache.sv
// Multi-block square-matrix store with row/col/diag access, registered reads and in-place transpose.
module mat_tile_cache
  import mat_pkg::*;
#(
  parameter int WIDTH           = 128,
  parameter int DATA_WIDTH      = 32,
  parameter int CACHE_SIZE      = 4,
  parameter int WIDTH_ADDR_SIZE = 1 + $clog2(WIDTH),
  parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
  input logic             clock,
  input logic             reset,
  mat_tile_cache_if.slave bus
);

  localparam int ROW_W = $clog2(WIDTH);

  logic [DATA_WIDTH-1:0]       mem_q [CACHE_SIZE][WIDTH][WIDTH];
  logic [WIDTH*DATA_WIDTH-1:0] data_out_q, rd_vec;
  logic                        rd_valid_q, rd_valid_d;
  logic                        rd_error_q, rd_error_d;
  logic                        rd_blocked;
  logic                        busy, swap_en;
  logic [ROW_W-1:0]            swap_row;
  logic [CACHE_ADDR_SIZE-1:0]  swap_blk;

  mat_cache_transpose_ctrl #(
    .WIDTH           (WIDTH),
    .CACHE_ADDR_SIZE (CACHE_ADDR_SIZE),
    .ROW_W           (ROW_W)
  ) u_tctrl (
    .clock             (clock),
    .reset             (reset),
    .transpose_start_i (bus.transpose_start),
    .transpose_addr_i  (bus.transpose_addr),
    .busy_o            (busy),
    .done_o            (bus.transpose_done),
    .swap_en_o         (swap_en),
    .swap_row_o        (swap_row),
    .swap_blk_o        (swap_blk)
  );

  // Storage: reset clear, transpose swap, else the (non-busy) write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: contents must read back as zero after reset, so the array is flops with a reset loop, not a RAM macro.
      for (int b = 0; b < CACHE_SIZE; b++)
        for (int r = 0; r < WIDTH; r++)
          for (int c = 0; c < WIDTH; c++)
            mem_q[b][r][c] <= '0;
    end else if (swap_en) begin
      // NOTE: non-blocking assignments let each pair exchange pre-edge values without a temporary.
      for (int j = 0; j < WIDTH; j++) begin
        if (j > int'(swap_row)) begin
          mem_q[swap_blk][swap_row][ROW_W'(j)] <= mem_q[swap_blk][ROW_W'(j)][swap_row];
          mem_q[swap_blk][ROW_W'(j)][swap_row] <= mem_q[swap_blk][swap_row][ROW_W'(j)];
        end
      end
    end else if (bus.write_enable) begin
      case (bus.write_type)
        WRITE_ROW: if (int'(bus.write_param) < WIDTH)
          for (int i = 0; i < WIDTH; i++)
            mem_q[bus.write_addr1][ROW_W'(bus.write_param)][ROW_W'(i)] <=
              bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
        WRITE_COL: if (int'(bus.write_param) < WIDTH)
          for (int i = 0; i < WIDTH; i++)
            mem_q[bus.write_addr1][ROW_W'(i)][ROW_W'(bus.write_param)] <=
              bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
        WRITE_DIAG: if (int'(bus.write_param) <= 2*WIDTH - 2)
          for (int i = 0; i < WIDTH; i++) begin
            if (i <= int'(bus.write_param)) begin
              if (int'(bus.write_param) - i < WIDTH)
                mem_q[bus.write_addr1][ROW_W'(i)][ROW_W'(int'(bus.write_param) - i)] <=
                  bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
              mem_q[bus.write_addr2][ROW_W'(i)][ROW_W'(WIDTH + int'(bus.write_param) - i)] <=
                bus.data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    // NOTE: the default covers every path (bad op, out-of-range param, off-matrix diag cells), so no latch.
    rd_vec = '0;
    case (bus.read_type)
      READ_ROW: if (int'(bus.read_param) < WIDTH)
        for (int i = 0; i < WIDTH; i++)
          rd_vec[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[bus.read_addr1][ROW_W'(bus.read_param)][ROW_W'(i)];
      READ_COL: if (int'(bus.read_param) < WIDTH)
        for (int i = 0; i < WIDTH; i++)
          rd_vec[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[bus.read_addr1][ROW_W'(i)][ROW_W'(bus.read_param)];
      READ_DIAG: if (int'(bus.read_param) <= 2*WIDTH - 2)
        for (int i = 0; i < WIDTH; i++) begin
          if (i <= int'(bus.read_param)) begin
            if (int'(bus.read_param) - i < WIDTH)
              rd_vec[i*DATA_WIDTH +: DATA_WIDTH] =
                mem_q[bus.read_addr1][ROW_W'(i)][ROW_W'(int'(bus.read_param) - i)];
          end else begin
            rd_vec[i*DATA_WIDTH +: DATA_WIDTH] =
              mem_q[bus.read_addr2][ROW_W'(i)][ROW_W'(WIDTH + int'(bus.read_param) - i)];
          end
        end
      default: ;
    endcase
  end

  // A diag read names two blocks; either one being transposed drops the read.
  assign rd_blocked = busy && ((bus.read_addr1 == swap_blk) ||
                               (bus.read_type == READ_DIAG && bus.read_addr2 == swap_blk));
  assign rd_valid_d = bus.read_enable && !rd_blocked;
  assign rd_error_d = bus.read_enable && rd_blocked;

  always_ff @(posedge clock) begin
    if (reset) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      rd_error_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_error_q <= rd_error_d;
      if (rd_valid_d) data_out_q <= rd_vec;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.read_valid = rd_valid_q;
  assign bus.read_error = rd_error_q;
  assign bus.busy       = busy;

endmodule
